// File: rtl/bus_arb2_if.sv
// Enable/ready register bus: the master holds enable (and its command) until it
// sees ready; ready, o_data and bus_err stay valid until enable drops.
interface bus_arb2_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    enable;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   i_data;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   o_data;
    logic                    bus_err;

    modport master (
        output enable, wr_en, addr, i_data, be,
        input  ready, o_data, bus_err
    );

    modport slave (
        input  enable, wr_en, addr, i_data, be,
        output ready, o_data, bus_err
    );
endinterface

// File: rtl/bus_arb2.sv
// Two-master round-robin arbiter in front of one enable/ready target, with a
// registered command path and a programmable hung-transaction timeout.
module bus_arb2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    bus_arb2_if.slave  m0,
    bus_arb2_if.slave  m1,
    bus_arb2_if.master s
);
    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_WIDTH'(TIMEOUT - 1) : '0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic                 TO_EN    = (TIMEOUT != 0);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0]            state_reg;
    logic                  grant_reg;
    logic                  last_grant_reg;
    logic [CNT_WIDTH-1:0]  cnt_reg;
    logic                  s_enable_reg;
    logic                  s_wr_en_reg;
    logic [ADDR_WIDTH-1:0] s_addr_reg;
    logic [DATA_WIDTH-1:0] s_i_data_reg;
    logic [BE_WIDTH-1:0]   s_be_reg;

    logic [1:0]            req;
    logic [1:0]            m_wr_en;
    logic [ADDR_WIDTH-1:0] m_addr   [2];
    logic [DATA_WIDTH-1:0] m_i_data [2];
    logic [BE_WIDTH-1:0]   m_be     [2];

    logic grant_next;
    logic done_ok;
    logic done_to;

    assign req         = {m1.enable, m0.enable};
    assign m_wr_en     = {m1.wr_en, m0.wr_en};
    assign m_addr[0]   = m0.addr;
    assign m_addr[1]   = m1.addr;
    assign m_i_data[0] = m0.i_data;
    assign m_i_data[1] = m1.i_data;
    assign m_be[0]     = m0.be;
    assign m_be[1]     = m1.be;

    // On contention the master that did not win last time goes first.
    always_comb begin
        grant_next = 1'b0;
        if (req == 2'b11) begin
            grant_next = ~last_grant_reg;
        end else if (req[1]) begin
            grant_next = 1'b1;
        end
    end

    assign done_ok = (state_reg == ST_BUSY) && s.ready;
    assign done_to = (state_reg == ST_BUSY) && !s.ready && TO_EN && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            cnt_reg        <= '0;
            s_enable_reg   <= 1'b0;
            s_wr_en_reg    <= 1'b0;
            s_addr_reg     <= '0;
            s_i_data_reg   <= '0;
            s_be_reg       <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        grant_reg    <= grant_next;
                        s_enable_reg <= 1'b1;
                        s_wr_en_reg  <= m_wr_en[grant_next];
                        s_addr_reg   <= m_addr[grant_next];
                        s_i_data_reg <= m_i_data[grant_next];
                        s_be_reg     <= m_be[grant_next];
                        cnt_reg      <= '0;
                        state_reg    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (done_ok || done_to) begin
                        s_enable_reg <= 1'b0;
                        state_reg    <= ST_RELEASE;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!req[grant_reg]) begin
                        last_grant_reg <= grant_reg;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Response registers per master; only the granted one ever leaves zero.
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        logic                  mine;
        logic                  ready_reg;
        logic                  bus_err_reg;
        logic [DATA_WIDTH-1:0] o_data_reg;

        assign mine = (grant_reg == 1'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ready_reg   <= 1'b0;
                bus_err_reg <= 1'b0;
                o_data_reg  <= '0;
            end else if (mine && done_ok) begin
                ready_reg   <= 1'b1;
                bus_err_reg <= s.bus_err;
                o_data_reg  <= s.o_data;
            end else if (mine && done_to) begin
                ready_reg   <= 1'b1;
                bus_err_reg <= 1'b1;
                o_data_reg  <= '0;
            end else if (mine && (state_reg == ST_RELEASE) && !req[gi]) begin
                ready_reg   <= 1'b0;
                bus_err_reg <= 1'b0;
                o_data_reg  <= '0;
            end
        end
    end

    assign m0.ready   = g_master[0].ready_reg;
    assign m0.o_data  = g_master[0].o_data_reg;
    assign m0.bus_err = g_master[0].bus_err_reg;
    assign m1.ready   = g_master[1].ready_reg;
    assign m1.o_data  = g_master[1].o_data_reg;
    assign m1.bus_err = g_master[1].bus_err_reg;

    assign s.enable = s_enable_reg;
    assign s.wr_en  = s_wr_en_reg;
    assign s.addr   = s_addr_reg;
    assign s.i_data = s_i_data_reg;
    assign s.be     = s_be_reg;
endmodule

// File: doc/bus_arb2.md
Name: bus_arb2

Overview:
- Two-master round-robin arbiter that shares one memory-mapped peripheral port (e.g. uart_mem) between two requesters.
- Each requester uses the enable/ready register-bus handshake.
- The arbiter registers the winning command, drives it to the shared target and returns read data/bus_err to the winner.
- A programmable timeout terminates hung transactions with bus_err.

Parameters:
- ADDR_WIDTH, 32, width of addr buses.
- DATA_WIDTH, 32, width of data buses; BE width = DATA_WIDTH/8.
- TIMEOUT, 1024, maximum cycles in BUSY before forced error completion; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  active-low reset.
- mX_enable  in  1  master X (X=0,1) request; held high until mX_ready seen.
- mX_wr_en  in  1  1=write, 0=read.
- mX_addr  in  ADDR_WIDTH  byte address.
- mX_i_data  in  DATA_WIDTH  write data.
- mX_be  in  DATA_WIDTH/8  byte enables.
- mX_ready  out  1  transaction complete; level, held until mX_enable drops.
- mX_o_data  out  DATA_WIDTH  read data, valid while mX_ready=1.
- mX_bus_err  out  1  error status, valid while mX_ready=1.
- s_enable  out  1  request to shared target.
- s_wr_en  out  1  registered command.
- s_addr  out  ADDR_WIDTH  registered command.
- s_i_data  out  DATA_WIDTH  registered command.
- s_be  out  DATA_WIDTH/8  registered command.
- s_ready  in  1  target completion.
- s_o_data  in  DATA_WIDTH  target read data.
- s_bus_err  in  1  target error.

Behaviour:
- Clocking/reset: single clock domain, rising edge. Reset is asynchronous and active-low on rst_n (clk/rst_n naming).
- Reset forces all outputs to 0, state to IDLE, last_grant to 1 (so m0 wins the first contention) and the timeout counter to 0.
- Reset mid-transaction abandons the transaction silently; s_enable drops immediately.
- FSM states: IDLE, BUSY, RELEASE. All outputs are registered.
- IDLE:
  - If exactly one mX_enable=1, grant X.
  - If both are 1, grant the master != last_grant.
  - On grant, capture that master's wr_en/addr/i_data/be into the s_* registers, set s_enable=1, clear the counter, go to BUSY.
  - Latency: request sampled at edge N, s_enable high after edge N.
- BUSY:
  - Command registers stay stable.
  - On s_ready=1: capture s_o_data and s_bus_err into the granted master's o_data/bus_err, set mX_ready=1, s_enable=0, go to RELEASE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: mX_o_data=0, mX_bus_err=1, mX_ready=1, s_enable=0, go to RELEASE.
  - Otherwise the counter increments.
  - The counter is $clog2(TIMEOUT+1) bits and never wraps.
- RELEASE:
  - Hold mX_ready/o_data/bus_err.
  - When the granted mX_enable=0 is sampled: clear mX_ready, mX_o_data, mX_bus_err; set last_grant=X; go to IDLE.
  - If enable was already low on RELEASE entry, ready is a one-cycle pulse.
- Inter-transaction gap: s_enable is low for at least one cycle between consecutive target transactions. Earliest new grant is one edge after RELEASE exits, giving a minimum 2-cycle gap between transactions.
- Non-granted master: its ready, o_data and bus_err stay 0. Its request stays pending (not dropped) and is served next because of round robin.
- s_ready sampled while in IDLE or RELEASE is ignored.
- Changes to a master's inputs after grant do not affect the command in flight.
- Fairness: with both masters requesting continuously, grants strictly alternate 0,1,0,1.

Test Plan:
- Single master write: m0 writes 0x01B2 to addr 0x0, be=0011; target ready after 3 cycles, bus_err=0 -> s_enable one edge after request; s_addr=0x0, s_i_data=0x01B2; m0_ready rises one edge after s_ready with m0_bus_err=0; m1 outputs stay 0.
- Read data return: m1 reads addr 0x8; target returns 0x1 with ready -> m1_o_data=0x00000001 held until m1_enable drops, then cleared to 0 next edge.
- Simultaneous requests out of reset: both enable on the same edge, held for 4 transactions -> grant order m0,m1,m0,m1; s_enable low at least 1 cycle between each.
- Error passthrough: m0 writes addr 0x18; target returns ready with bus_err=1 -> m0_bus_err=1 while m0_ready=1.
- Timeout: TIMEOUT=16; target never asserts ready -> exactly 16 cycles after s_enable rises, m0_ready=1, m0_bus_err=1, m0_o_data=0, s_enable=0.
- Reset mid-BUSY: assert rst_n=0 while s_enable=1 -> s_enable and all mX_ready drop asynchronously; after release, pending m1 and m0 requests grant m0 first.
